// File: rtl/dbu_pkg.sv
// ---------------------------------------------------------------------------
// dbu_pkg
// Shared types and constants for the board-side CPU debug unit.
//   dbuState_t     : run-control FSM state (HALT, STEP, RUN)
//   SEL_DEFAULT    : display-select value that shows status / memory / RF data
//   ADDR_W_DEFAULT : default width of the debug address register
// ---------------------------------------------------------------------------
package dbu_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2
    } dbuState_t;

    localparam logic [2:0] SEL_DEFAULT    = 3'd0;
    localparam int         ADDR_W_DEFAULT = 16;

endpackage

// File: rtl/dbu_debounce.sv
// ---------------------------------------------------------------------------
// dbu_debounce
// Two-flop synchroniser, optional debounce filter and rising-edge pulse
// generator for one push button.
//
// Configuration macro: DBU_DEBOUNCE_EN
//   defined   : the debounced level follows the synchronised level only after
//               the two have differed for DEBOUNCE_CYCLES consecutive cycles;
//               any bounce restarts the count. Press-to-pulse latency is
//               2 + DEBOUNCE_CYCLES + 1 cycles.
//   undefined : no filter, the debounced level is the synchronised level and
//               press-to-pulse latency is 3 cycles.
//
// Ports:
//   clk     in   board clock
//   rst     in   asynchronous active-high reset
//   i_btn   in   raw (asynchronous, bouncy) button level
//   o_rise  out  one-cycle pulse, the cycle after the debounced level rises
// ---------------------------------------------------------------------------
module dbu_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_rise;
    logic w_level;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DBU_DEBOUNCE_EN
    // Counter only needs to reach DEBOUNCE_CYCLES-1; the level flips on the
    // cycle the count would otherwise reach DEBOUNCE_CYCLES.
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_level;

    // Accept a new level only after it has been stable long enough; a return
    // to the current level at any point clears the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 == r_level) begin
            r_count <= '0;
        end else if (r_count == CNT_LAST) begin
            r_count <= '0;
            r_level <= r_sync2;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign w_level = r_level;
`else
    assign w_level = r_sync2;
`endif

    // Registered 0->1 detector on the debounced level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= w_level;
            r_rise <= w_level & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/cpu_debug_unit.sv
// ---------------------------------------------------------------------------
// cpu_debug_unit
// Board-side debug unit in front of the pipelined CPU. Gates CPU progress
// (continuous run or single step), drives the CPU debug address / select,
// and muxes CPU debug data onto the LED bank and the 7-segment bus.
//
// Configuration macro: DBU_DEBOUNCE_EN (see dbu_debounce); when undefined the
// button debounce is bypassed and DEBOUNCE_CYCLES has no effect.
//
// Ports:
//   clk         in   board clock
//   rst         in   asynchronous active-high reset
//   succ        in   switch, 1 = continuous run
//   step        in   button, single-step request
//   sel[2:0]    in   display select switches, forwarded as i_sel
//   m_rf        in   switch, 1 = data memory view, 0 = register file view
//   inc         in   button, debug address + 1
//   dec         in   button, debug address - 1
//   status      in   CPU control status
//   m_data      in   CPU data memory debug read
//   rf_data     in   CPU register file debug read
//   o_sel_data  in   CPU selected internal register
//   run_en      out  CPU clock enable
//   i_sel       out  select to CPU
//   m_rf_addr   out  debug address to CPU
//   led         out  LED bank
//   disp_data   out  7-segment display value
// ---------------------------------------------------------------------------
module cpu_debug_unit
    import dbu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int          ADDR_W          = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              succ,
    input  logic              step,
    input  logic [2:0]        sel,
    input  logic              m_rf,
    input  logic              inc,
    input  logic              dec,
    input  logic [15:0]       status,
    input  logic [31:0]       m_data,
    input  logic [31:0]       rf_data,
    input  logic [31:0]       o_sel_data,
    output logic              run_en,
    output logic [2:0]        i_sel,
    output logic [ADDR_W-1:0] m_rf_addr,
    output logic [15:0]       led,
    output logic [31:0]       disp_data
);

    logic              w_stepRise;
    logic              w_incRise;
    logic              w_decRise;
    logic              r_succSync1;
    logic              r_succS;
    dbuState_t         r_state;
    logic              r_runEn;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_led;
    logic [31:0]       r_disp;

    dbu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uStepBtn (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (step),
        .o_rise (w_stepRise)
    );

    dbu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uIncBtn (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (inc),
        .o_rise (w_incRise)
    );

    dbu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDecBtn (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (dec),
        .o_rise (w_decRise)
    );

    // The run switch is a stable toggle, so synchronising it is enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_succSync1 <= 1'b0;
            r_succS     <= 1'b0;
        end else begin
            r_succSync1 <= succ;
            r_succS     <= r_succSync1;
        end
    end

    // Run-control FSM. run_en is registered alongside the state so it always
    // equals the decode of the state it is loaded with; a step pulse seen in
    // STEP or RUN is simply ignored, and the run switch wins over a step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HALT;
            r_runEn <= 1'b0;
        end else begin
            case (r_state)
                HALT: begin
                    if (r_succS) begin
                        r_state <= RUN;
                        r_runEn <= 1'b1;
                    end else if (w_stepRise) begin
                        r_state <= STEP;
                        r_runEn <= 1'b1;
                    end else begin
                        r_runEn <= 1'b0;
                    end
                end
                STEP: begin
                    r_state <= HALT;
                    r_runEn <= 1'b0;
                end
                RUN: begin
                    if (!r_succS) begin
                        r_state <= HALT;
                        r_runEn <= 1'b0;
                    end else begin
                        r_runEn <= 1'b1;
                    end
                end
                default: begin
                    r_state <= HALT;
                    r_runEn <= 1'b0;
                end
            endcase
        end
    end

    // Debug address walks with the buttons independently of the run state;
    // natural modular arithmetic gives the wrap in both directions, and
    // opposing presses in the same cycle cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (w_incRise && !w_decRise) begin
            r_addr <= r_addr + 1'b1;
        end else if (w_decRise && !w_incRise) begin
            r_addr <= r_addr - 1'b1;
        end
    end

    // Display mux, registered once so the board outputs come straight from
    // flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led  <= '0;
            r_disp <= '0;
        end else if (sel == SEL_DEFAULT) begin
            r_led  <= status;
            r_disp <= m_rf ? m_data : rf_data;
        end else begin
            r_led  <= 16'(r_addr);
            r_disp <= o_sel_data;
        end
    end

    assign run_en    = r_runEn;
    assign i_sel     = sel;
    assign m_rf_addr = r_addr;
    assign led       = r_led;
    assign disp_data = r_disp;

endmodule

// File: tb/tb_cpu_debug_unit.sv
// ---------------------------------------------------------------------------
// tb_cpu_debug_unit
// Directed self-checking bench for cpu_debug_unit. Expected timings are
// derived from the button pulse latency, which depends on DBU_DEBOUNCE_EN.
// ---------------------------------------------------------------------------
module tb_cpu_debug_unit;

    localparam int DB = 4;
`ifdef DBU_DEBOUNCE_EN
    localparam int PLAT = 2 + DB + 1;
`else
    localparam int PLAT = 3;
`endif

    logic        clk;
    logic        rst;
    logic        succ;
    logic        step;
    logic [2:0]  sel;
    logic        m_rf;
    logic        inc;
    logic        dec;
    logic [15:0] status;
    logic [31:0] m_data;
    logic [31:0] rf_data;
    logic [31:0] o_sel_data;
    logic        run_en;
    logic [2:0]  i_sel;
    logic [15:0] m_rf_addr;
    logic [15:0] led;
    logic [31:0] disp_data;

    int errCount;
    int checkCount;

    cpu_debug_unit #(.DEBOUNCE_CYCLES(DB), .ADDR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .succ       (succ),
        .step       (step),
        .sel        (sel),
        .m_rf       (m_rf),
        .inc        (inc),
        .dec        (dec),
        .status     (status),
        .m_data     (m_data),
        .rf_data    (rf_data),
        .o_sel_data (o_sel_data),
        .run_en     (run_en),
        .i_sel      (i_sel),
        .m_rf_addr  (m_rf_addr),
        .led        (led),
        .disp_data  (disp_data)
    );

    // Free-running 10-unit board clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the three buttons {step, inc, dec}.
    task automatic applyStimulus(input logic [2:0] btns);
        step = btns[2];
        inc  = btns[1];
        dec  = btns[0];
    endtask

    // Full press and release of the given buttons, long enough to register.
    task automatic pressRelease(input logic [2:0] btns);
        applyStimulus(btns);
        repeat (PLAT + 2) tick();
        applyStimulus(3'b000);
        repeat (PLAT + 2) tick();
    endtask

    initial begin
        errCount   = 0;
        checkCount = 0;
        rst        = 1'b1;
        succ       = 1'b0;
        sel        = 3'd0;
        m_rf       = 1'b0;
        status     = 16'h1234;
        m_data     = 32'h11111111;
        rf_data    = 32'h22222222;
        o_sel_data = 32'h33333333;
        applyStimulus(3'b000);

        // Reset state.
        repeat (3) tick();
        checkOutput("reset run_en", {31'd0, run_en}, 32'd0);
        checkOutput("reset m_rf_addr", {16'd0, m_rf_addr}, 32'd0);
        checkOutput("reset led", {16'd0, led}, 32'd0);
        checkOutput("reset disp_data", disp_data, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Single step: one run_en pulse, PLAT+1 edges after the press.
        applyStimulus(3'b100);
        for (int n = 1; n <= PLAT + 4; n++) begin
            tick();
            checkOutput($sformatf("step pulse c%0d", n), {31'd0, run_en},
                        (n == PLAT + 1) ? 32'd1 : 32'd0);
        end
        applyStimulus(3'b000);
        for (int n = 1; n <= PLAT + 2; n++) begin
            tick();
            checkOutput("step release run_en", {31'd0, run_en}, 32'd0);
        end

`ifdef DBU_DEBOUNCE_EN
        // Bouncing step: never stable long enough, then a clean hold.
        for (int i = 0; i < 12; i++) begin
            step = ((i / 2) % 2) == 0;
            tick();
            checkOutput("bounce run_en", {31'd0, run_en}, 32'd0);
        end
        step = 1'b1;
        for (int n = 1; n <= PLAT + 3; n++) begin
            tick();
            checkOutput($sformatf("bounce hold c%0d", n), {31'd0, run_en},
                        (n == PLAT + 1) ? 32'd1 : 32'd0);
        end
        step = 1'b0;
        repeat (PLAT + 2) tick();
`endif

        // Continuous run: enable on the third edge after the switch moves.
        succ = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            checkOutput($sformatf("run on c%0d", n), {31'd0, run_en},
                        (n >= 3) ? 32'd1 : 32'd0);
        end
        applyStimulus(3'b100);
        for (int n = 1; n <= PLAT + 3; n++) begin
            tick();
            checkOutput("step while run", {31'd0, run_en}, 32'd1);
        end
        applyStimulus(3'b000);
        repeat (PLAT + 2) tick();
        succ = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            tick();
            checkOutput($sformatf("run off c%0d", n), {31'd0, run_en},
                        (n < 3) ? 32'd1 : 32'd0);
        end

        // Address wrap down and up, then simultaneous inc/dec.
        applyStimulus(3'b001);
        for (int n = 1; n <= PLAT + 3; n++) begin
            tick();
            checkOutput($sformatf("dec wrap c%0d", n), {16'd0, m_rf_addr},
                        (n >= PLAT + 1) ? 32'h0000FFFF : 32'h00000000);
        end
        applyStimulus(3'b000);
        repeat (PLAT + 2) tick();
        applyStimulus(3'b010);
        for (int n = 1; n <= PLAT + 3; n++) begin
            tick();
            checkOutput($sformatf("inc wrap c%0d", n), {16'd0, m_rf_addr},
                        (n >= PLAT + 1) ? 32'h00000000 : 32'h0000FFFF);
        end
        applyStimulus(3'b000);
        repeat (PLAT + 2) tick();
        pressRelease(3'b010);
        checkOutput("inc to 1", {16'd0, m_rf_addr}, 32'h00000001);
        applyStimulus(3'b011);
        for (int n = 1; n <= PLAT + 3; n++) begin
            tick();
            checkOutput("inc+dec hold", {16'd0, m_rf_addr}, 32'h00000001);
        end
        applyStimulus(3'b000);
        repeat (PLAT + 2) tick();
        pressRelease(3'b010);
        pressRelease(3'b010);
        checkOutput("addr at 3", {16'd0, m_rf_addr}, 32'h00000003);

        // Display mux, default view.
        sel    = 3'd0;
        m_rf   = 1'b1;
        m_data = 32'hDEADBEEF;
        status = 16'h00A5;
        tick();
        checkOutput("disp mem view", disp_data, 32'hDEADBEEF);
        checkOutput("led status", {16'd0, led}, 32'h000000A5);
        m_rf    = 1'b0;
        rf_data = 32'h12345678;
        tick();
        checkOutput("disp rf view", disp_data, 32'h12345678);

        // Display mux, selected-register view.
        sel        = 3'd1;
        o_sel_data = 32'h00000040;
        #1;
        checkOutput("i_sel passthrough", {29'd0, i_sel}, 32'd1);
        checkOutput("led before edge", {16'd0, led}, 32'h000000A5);
        tick();
        checkOutput("disp sel data", disp_data, 32'h00000040);
        checkOutput("led addr", {16'd0, led}, 32'h00000003);
        sel = 3'd5;
        #1;
        checkOutput("i_sel 5", {29'd0, i_sel}, 32'd5);

        // Reset during RUN with a non-zero address.
        for (int i = 0; i < 13; i++) pressRelease(3'b010);
        checkOutput("addr at 0x10", {16'd0, m_rf_addr}, 32'h00000010);
        succ = 1'b1;
        repeat (4) tick();
        checkOutput("run before rst", {31'd0, run_en}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst run_en", {31'd0, run_en}, 32'd0);
        checkOutput("async rst addr", {16'd0, m_rf_addr}, 32'd0);
        checkOutput("async rst disp", disp_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            tick();
            checkOutput($sformatf("rerun c%0d", n), {31'd0, run_en},
                        (n >= 3) ? 32'd1 : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
